// File: rtl/led_pkg.sv
// Shared types and defaults for the LED frame scheduler: FSM states, sticker colour table, frame geometry.
package led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SNAP,
      ST_SEND,
      ST_LATCH
   } state_t;

   localparam int DEF_FACES          = 6;
   localparam int DEF_PIX_PER_FACE   = 64;
   localparam int DEF_LATCH_CYCLES   = 2000;
   localparam int DEF_REFRESH_CYCLES = 1_333_333;

   localparam logic [23:0] CLR_0     = 24'h00b000;
   localparam logic [23:0] CLR_1     = 24'h00f060;
   localparam logic [23:0] CLR_2     = 24'h00b0b0;
   localparam logic [23:0] CLR_3     = 24'h0000b0;
   localparam logic [23:0] CLR_4     = 24'hb00000;
   localparam logic [23:0] CLR_5     = 24'hb05000;
   localparam logic [23:0] CLR_BLANK = 24'h000000;

   function automatic logic [23:0] code_to_rgb(input logic [2:0] code);
      logic [23:0] rgb;
      case (code)
         3'd0:    rgb = CLR_0;
         3'd1:    rgb = CLR_1;
         3'd2:    rgb = CLR_2;
         3'd3:    rgb = CLR_3;
         3'd4:    rgb = CLR_4;
         3'd5:    rgb = CLR_5;
         default: rgb = CLR_BLANK;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/pixel_mapper.sv
// Combinational map from (orientation snapshot, frame pixel index) to a 24-bit colour word.
// Each face is an 8x8 serpentine; rows/cols 2 and 5 are the dark gaps between the 3x3 stickers.
module pixel_mapper
   import led_pkg::*;
(
   input  logic [161:0] shadow,
   input  logic [8:0]   pix_idx,
   output logic [23:0]  colour
);

   logic [2:0] face, col, r, row, srow, scol;
   logic [3:0] k;
   logic [7:0] base;
   logic       blank;

   always_comb begin
      face  = pix_idx[8:6];
      col   = pix_idx[5:3];
      r     = pix_idx[2:0];
      row   = col[0] ? (3'd7 - r) : r;
      blank = (row == 3'd2) || (row == 3'd5) || (col == 3'd2) || (col == 3'd5);
      srow  = row / 3'd3;
      scol  = col / 3'd3;
      // sticker columns also snake, so odd sticker columns count bottom-up
      k     = {1'b0, scol} * 4'd3 + (scol[0] ? (4'd2 - {1'b0, srow}) : {1'b0, srow});
      base  = 8'd27 * {5'd0, face} + 8'd26 - 8'd3 * {4'd0, k};
      colour = blank ? CLR_BLANK : code_to_rgb(shadow[base -: 3]);
   end

endmodule

// File: rtl/led_frame_scheduler.sv
// Streams six 8x8 faces as 24-bit words to the WS2812B serializer, one word per valid/ready handshake,
// then holds the latch gap; word 0 is valid two cycles after the update edge. Refresh timer under FRAME_REFRESH_EN.
module led_frame_scheduler
   import led_pkg::*;
#(
   parameter int FACES          = DEF_FACES,
   parameter int PIX_PER_FACE   = DEF_PIX_PER_FACE,
   parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES
`ifdef FRAME_REFRESH_EN
   , parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
`endif
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [161:0] orientation,
   input  logic         pix_ready,
   output logic         pix_valid,
   output logic [23:0]  pix_data,
   output logic         busy,
   output logic         frame_done
);

   localparam int         LW       = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam logic [8:0] LAST_IDX = 9'(FACES * PIX_PER_FACE - 1);

   state_t         state, state_nxt;
   logic           load_q, upd_pend, ref_pend;
   logic [8:0]     pix_idx;
   logic [LW-1:0]  lat_cnt;
   logic [161:0]   shadow;
   logic           fall, accept, last_acc, lat_done, enter_send, ref_clr;
   logic [161:0]   map_src;
   logic [8:0]     map_idx;
   logic [23:0]    map_rgb;

   assign fall       = load_q & ~load;
   assign accept     = pix_valid & pix_ready;
   assign last_acc   = accept && (pix_idx == LAST_IDX);
   assign lat_done   = (state == ST_LATCH) && (lat_cnt == LW'(LATCH_CYCLES - 1));
   assign enter_send = (state_nxt == ST_SEND) && (state != ST_SEND);
   assign ref_clr    = ((state == ST_IDLE) && (state_nxt == ST_SEND)) || (state == ST_SNAP);
   assign busy       = (state != ST_IDLE);

   // SNAP feeds the live bus so word 0 is ready in the same edge the shadow captures it
   assign map_src = (state == ST_SNAP) ? orientation : shadow;
   assign map_idx = (state == ST_SEND) ? (pix_idx + 9'd1) : 9'd0;

   pixel_mapper u_mapper (
      .shadow  (map_src),
      .pix_idx (map_idx),
      .colour  (map_rgb)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (upd_pend && !load) state_nxt = ST_SNAP;
            else if (ref_pend)     state_nxt = ST_SEND;
         end
         ST_SNAP:  state_nxt = ST_SEND;
         ST_SEND:  if (last_acc) state_nxt = ST_LATCH;
         ST_LATCH: if (lat_done) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         load_q     <= 1'b1;
         upd_pend   <= 1'b0;
         shadow     <= '1;
         pix_idx    <= '0;
         pix_valid  <= 1'b0;
         pix_data   <= '0;
         lat_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         load_q     <= load;
         frame_done <= lat_done;
         if (fall)                      upd_pend <= 1'b1;
         else if (state == ST_SNAP)     upd_pend <= 1'b0;
         if (state == ST_SNAP)          shadow   <= orientation;
         if (enter_send) begin
            pix_valid <= 1'b1;
            pix_data  <= map_rgb;
         end else if (last_acc) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_idx   <= '0;
         end else if (accept) begin
            pix_data  <= map_rgb;
            pix_idx   <= pix_idx + 9'd1;
         end
         if (state == ST_LATCH) lat_cnt <= lat_done ? '0 : lat_cnt + LW'(1);
      end
   end

`ifdef FRAME_REFRESH_EN
   localparam int RW = $clog2(REFRESH_CYCLES);
   logic [RW-1:0] ref_cnt;
   logic          ref_wrap;

   assign ref_wrap = (ref_cnt == RW'(REFRESH_CYCLES - 1));

   // a wrap coinciding with a frame start is served by that frame
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ref_cnt  <= '0;
         ref_pend <= 1'b0;
      end else begin
         ref_cnt <= ref_wrap ? '0 : ref_cnt + RW'(1);
         if (ref_clr)       ref_pend <= 1'b0;
         else if (ref_wrap) ref_pend <= 1'b1;
      end
   end
`else
   logic unused_ref_clr;
   assign unused_ref_clr = ref_clr;
   assign ref_pend       = 1'b0;
`endif

endmodule
